fall_detect_sequencer: RTL and testbench

- Time-shared controller that sequences the fall-detection datapath: periodic sample capture, gravity-window check, SVM (sum of squared axes) through one shared 16x16 multiplier over three cycles, threshold compare, N-consecutive-hit confirmation, and a timed alarm hold.
- Sits between the accelerometer reader (AX/AY/AZ registers) and the alarm/display logic.
- Exports a debug status byte for LEDs.

---
 rtl/fall_detect_sequencer_if.sv | 24 ++
 rtl/fall_detect_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_fall_detect_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fall_detect_sequencer_if.sv
// Bus between the accelerometer reader / alarm logic and the fall-detection sequencer.
// There is no valid/ready handshake: the axis inputs are sampled once, in CAPTURE, and
// alarm_ack is a level honoured only in HOLD; every output is a registered level.
interface fall_detect_sequencer_if;
    logic signed [15:0] ax_data;
    logic signed [15:0] ay_data;
    logic signed [15:0] az_data;
    logic               alarm_ack;
    logic               fall;
    logic               busy;
    logic [31:0]        svm;
    logic [7:0]         status;
    logic [2:0]         dbg_state;

    modport master (
        output ax_data, ay_data, az_data, alarm_ack,
        input  fall, busy, svm, status, dbg_state
    );

    modport slave (
        input  ax_data, ay_data, az_data, alarm_ack,
        output fall, busy, svm, status, dbg_state
    );
endinterface

// File: rtl/fall_detect_sequencer.sv
// Time-shared fall-detection controller: tick-driven capture, gravity window, three-cycle
// SVM accumulation through one squarer, threshold compare, hit confirmation and alarm hold.
module fall_detect_sequencer #(
    parameter int unsigned TICK_DIV    = 524288,
    parameter int          T_GRAVITY   = 18000,
    parameter int unsigned T_SVM       = 500000000,
    parameter int unsigned CONFIRM     = 1,
    parameter int unsigned HOLD_CYCLES = 100000000
) (
    input  logic                    clk,
    input  logic                    reset,
    fall_detect_sequencer_if.slave  bus
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CAPTURE, S_GCHK, S_MAC_X, S_MAC_Y, S_MAC_Z, S_SCHK, S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic signed [15:0] ax_lat_q, ax_lat_d;
    logic signed [15:0] ay_lat_q, ay_lat_d;
    logic signed [15:0] az_lat_q, az_lat_d;
    logic [31:0]        acc_q, acc_d;
    logic [31:0]        svm_q, svm_d;
    logic [3:0]         hits_q, hits_d;
    logic               fall_q, fall_d;
    logic               busy_q, busy_d;
    logic               spass_q, spass_d;
    logic               gpass_q, gpass_d;
    logic               drop_q, drop_d;

    logic               tick;
    logic signed [15:0] mac_op;
    logic [15:0]        mac_mag;
    logic [31:0]        mac_sq;
    logic [3:0]         hits_inc;
    logic               az_in_window;

    assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

    // Single shared squarer; the operand follows the MAC state. |-32768| still fits 16 bits unsigned.
    always_comb begin
        case (state_q)
            S_MAC_X: mac_op = ax_lat_q;
            S_MAC_Y: mac_op = ay_lat_q;
            default: mac_op = az_lat_q;
        endcase
        mac_mag = mac_op[15] ? 16'(-mac_op) : 16'(mac_op);
        mac_sq  = 32'(mac_mag) * 32'(mac_mag);
    end

    assign hits_inc     = (hits_q == 4'hF) ? 4'hF : hits_q + 4'd1;
    assign az_in_window = (az_lat_q > 16'sd0) && (int'(az_lat_q) < T_GRAVITY);

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        hold_d     = hold_q;
        ax_lat_d   = ax_lat_q;
        ay_lat_d   = ay_lat_q;
        az_lat_d   = az_lat_q;
        acc_d      = acc_q;
        svm_d      = svm_q;
        hits_d     = hits_q;
        fall_d     = fall_q;
        spass_d    = spass_q;
        gpass_d    = gpass_q;
        drop_d     = drop_q;

        // A tick that finds the sequencer busy is lost; remember that for the LEDs.
        if (tick && (state_q != S_IDLE)) begin
            drop_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (tick) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                ax_lat_d = bus.ax_data;
                ay_lat_d = bus.ay_data;
                az_lat_d = bus.az_data;
                acc_d    = '0;
                spass_d  = 1'b0;
                gpass_d  = 1'b0;
                state_d  = S_GCHK;
            end
            S_GCHK: begin
                if (az_in_window) begin
                    gpass_d = 1'b1;
                    state_d = S_MAC_X;
                end else begin
                    hits_d  = '0;
                    state_d = S_IDLE;
                end
            end
            S_MAC_X: begin
                acc_d   = acc_q + mac_sq;
                state_d = S_MAC_Y;
            end
            S_MAC_Y: begin
                acc_d   = acc_q + mac_sq;
                state_d = S_MAC_Z;
            end
            S_MAC_Z: begin
                acc_d   = acc_q + mac_sq;
                state_d = S_SCHK;
            end
            S_SCHK: begin
                svm_d = acc_q;
                if (acc_q > 32'(T_SVM)) begin
                    spass_d = 1'b1;
                    hits_d  = hits_inc;
                    if (hits_inc == 4'(CONFIRM)) begin
                        fall_d  = 1'b1;
                        hold_d  = '0;
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    hits_d  = '0;
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (bus.alarm_ack || (hold_q == HW'(HOLD_CYCLES - 1))) begin
                    fall_d  = 1'b0;
                    hits_d  = '0;
                    hold_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            hold_q     <= '0;
            ax_lat_q   <= '0;
            ay_lat_q   <= '0;
            az_lat_q   <= '0;
            acc_q      <= '0;
            svm_q      <= '0;
            hits_q     <= '0;
            fall_q     <= 1'b0;
            busy_q     <= 1'b0;
            spass_q    <= 1'b0;
            gpass_q    <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            hold_q     <= hold_d;
            ax_lat_q   <= ax_lat_d;
            ay_lat_q   <= ay_lat_d;
            az_lat_q   <= az_lat_d;
            acc_q      <= acc_d;
            svm_q      <= svm_d;
            hits_q     <= hits_d;
            fall_q     <= fall_d;
            busy_q     <= busy_d;
            spass_q    <= spass_d;
            gpass_q    <= gpass_d;
            drop_q     <= drop_d;
        end
    end

    assign bus.fall      = fall_q;
    assign bus.busy      = busy_q;
    assign bus.svm       = svm_q;
    assign bus.status    = {fall_q, spass_q, gpass_q, drop_q, hits_q};
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_fall_detect_sequencer.sv
// Bench for fall_detect_sequencer: one instance with CONFIRM=1 and one with CONFIRM=3,
// both on a 16-cycle tick and a 50-cycle hold, sharing the same axis stimulus.
module tb_fall_detect_sequencer;

    localparam int TICK_DIV = 16;
    localparam int HOLD     = 50;

    typedef struct {
        logic signed [15:0] ax;
        logic signed [15:0] ay;
        logic signed [15:0] az;
        bit                 gpass;
        bit                 spass;
        logic [3:0]         hits;
        bit                 fall;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fall_detect_sequencer_if if_a ();
    fall_detect_sequencer_if if_b ();

    fall_detect_sequencer #(
        .TICK_DIV(TICK_DIV), .T_GRAVITY(18000), .T_SVM(500000000),
        .CONFIRM(1), .HOLD_CYCLES(HOLD)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(if_a.slave)
    );

    fall_detect_sequencer #(
        .TICK_DIV(TICK_DIV), .T_GRAVITY(18000), .T_SVM(500000000),
        .CONFIRM(3), .HOLD_CYCLES(HOLD)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(if_b.slave)
    );

    // Independent tick phase: counts clocks since reset release, wrapping every TICK_DIV.
    int tb_cnt;
    always @(posedge clk or negedge reset) begin
        if (!reset) tb_cnt <= 0;
        else        tb_cnt <= (tb_cnt == TICK_DIV - 1) ? 0 : tb_cnt + 1;
    end

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  exp_st_q[$];
    logic [31:0] last_svm;
    bit          exp_drop;
    vec_t        tab_a[9];
    vec_t        tab_b[6];

    function automatic vec_t mk(int ax, int ay, int az, bit g, bit s, int h, bit f);
        vec_t v;
        v.ax = 16'(ax); v.ay = 16'(ay); v.az = 16'(az);
        v.gpass = g; v.spass = s; v.hits = 4'(h); v.fall = f;
        return v;
    endfunction

    function automatic logic [31:0] get_svm(int sel);
        return (sel != 0) ? if_b.svm : if_a.svm;
    endfunction
    function automatic logic [7:0] get_status(int sel);
        return (sel != 0) ? if_b.status : if_a.status;
    endfunction
    function automatic logic get_fall(int sel);
        return (sel != 0) ? if_b.fall : if_a.fall;
    endfunction
    function automatic logic get_busy(int sel);
        return (sel != 0) ? if_b.busy : if_a.busy;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic drive_axes(input vec_t v);
        if_a.ax_data = v.ax; if_a.ay_data = v.ay; if_a.az_data = v.az;
        if_b.ax_data = v.ax; if_b.ay_data = v.ay; if_b.az_data = v.az;
    endtask

    task automatic drive_ack(input logic a);
        if_a.alarm_ack = a;
        if_b.alarm_ack = a;
    endtask

    // Returns at the negedge of the tick cycle.
    task automatic wait_tick();
        for (int i = 0; i < 4 * TICK_DIV; i++) begin
            @(negedge clk);
            if (tb_cnt == TICK_DIV - 1) return;
        end
        check("tick_timeout", 32'd0, 32'd1);
    endtask

    // Drives one sample, checks the result 7 clocks after its tick, optionally follows the full hold.
    task automatic run_sample(input int sel, input vec_t v, input bit wait_hold, input bit ack_entry);
        longint sq;
        drive_axes(v);
        wait_tick();
        sq = longint'(v.ax) * v.ax + longint'(v.ay) * v.ay + longint'(v.az) * v.az;
        last_svm = v.gpass ? 32'(sq) : last_svm;
        exp_q.push_back(last_svm);
        exp_st_q.push_back({v.fall, v.spass, v.gpass, exp_drop, v.hits});
        repeat (6) @(negedge clk);
        if (ack_entry) drive_ack(1'b1);
        @(negedge clk);
        check("svm", get_svm(sel), exp_q.pop_front());
        check("status", 32'(get_status(sel)), 32'(exp_st_q.pop_front()));
        check("fall", 32'(get_fall(sel)), 32'(v.fall));
        check("busy", 32'(get_busy(sel)), 32'(v.fall));
        if (v.fall && wait_hold) begin
            repeat (HOLD - 1) @(negedge clk);
            check("hold_last_fall", 32'(get_fall(sel)), 32'd1);
            @(negedge clk);
            exp_drop = 1'b1;
            check("hold_exit_fall", 32'(get_fall(sel)), 32'd0);
            check("hold_exit_status", 32'(get_status(sel)), 32'({1'b0, v.spass, v.gpass, 1'b1, 4'd0}));
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        exp_drop = 1'b0;
        last_svm = '0;
        exp_q.delete();
        exp_st_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t hit_v;
        vec_t near_v;
        hit_v  = mk(20000, 10000, 10000, 1, 1, 1, 1);
        near_v = mk(0, 20000, 10000, 1, 0, 0, 0);

        tab_a[0] = mk(20000, 10000, 20000, 0, 0, 0, 0);
        tab_a[1] = mk(20000, 10000, 0, 0, 0, 0, 0);
        tab_a[2] = mk(20000, 10000, -5000, 0, 0, 0, 0);
        tab_a[3] = near_v;
        tab_a[4] = hit_v;
        tab_a[5] = mk(-32768, 0, 1, 1, 1, 1, 1);
        tab_a[6] = mk(0, 0, 17999, 1, 0, 0, 0);
        tab_a[7] = mk(0, 0, 18000, 0, 0, 0, 0);
        tab_a[8] = mk(-32768, -32768, 17999, 1, 1, 1, 1);

        tab_b[0] = mk(20000, 10000, 10000, 1, 1, 1, 0);
        tab_b[1] = mk(20000, 10000, 10000, 1, 1, 2, 0);
        tab_b[2] = near_v;
        tab_b[3] = mk(20000, 10000, 10000, 1, 1, 1, 0);
        tab_b[4] = mk(20000, 10000, 10000, 1, 1, 2, 0);
        tab_b[5] = mk(20000, 10000, 10000, 1, 1, 3, 1);

        drive_axes(mk(0, 0, 0, 0, 0, 0, 0));
        drive_ack(1'b0);
        exp_drop = 1'b0;
        last_svm = '0;
        repeat (3) @(negedge clk);
        check("rst_fall", 32'(if_a.fall), 32'd0);
        check("rst_busy", 32'(if_a.busy), 32'd0);
        check("rst_svm", if_a.svm, 32'd0);
        check("rst_status", 32'(if_a.status), 32'd0);
        reset = 1'b1;

        // CONFIRM=1: gravity rejects, threshold boundary, falls, extreme axes.
        for (int i = 0; i < 9; i++) begin
            run_sample(0, tab_a[i], tab_a[i].fall, 1'b0);
        end

        // alarm_ack already high on entry to HOLD: one-cycle hold.
        hit_v.hits = 4'd1;
        run_sample(0, hit_v, 1'b0, 1'b1);
        @(negedge clk);
        check("ack_entry_fall", 32'(if_a.fall), 32'd0);
        check("ack_entry_status", 32'(if_a.status), 32'(8'h70));
        drive_ack(1'b0);

        // alarm_ack pulsed 5 clocks into HOLD, then the next tick runs normally.
        run_sample(0, hit_v, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        drive_ack(1'b1);
        @(negedge clk);
        drive_ack(1'b0);
        check("early_ack_fall", 32'(if_a.fall), 32'd0);
        check("early_ack_busy", 32'(if_a.busy), 32'd0);
        check("early_ack_status", 32'(if_a.status), 32'(8'h70));
        run_sample(0, near_v, 1'b0, 1'b0);

        // Reset 10 clocks into HOLD aborts the alarm; a fresh sequence follows.
        run_sample(0, hit_v, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midhold_rst_fall", 32'(if_a.fall), 32'd0);
        check("midhold_rst_busy", 32'(if_a.busy), 32'd0);
        check("midhold_rst_status", 32'(if_a.status), 32'd0);
        check("midhold_rst_svm", if_a.svm, 32'd0);
        exp_drop = 1'b0;
        last_svm = '0;
        @(negedge clk);
        reset = 1'b1;
        run_sample(0, hit_v, 1'b1, 1'b0);

        // CONFIRM=3: hit, hit, miss, hit, hit, hit.
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            run_sample(1, tab_b[i], tab_b[i].fall, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
